// File: rtl/mpu_pkg.sv
// Shared constants for the MPU6050 burst reader: FSM encoding, register map
// anchors and a big-endian word helper.
package mpu_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_NEXT    = 3'd3;
    localparam logic [2:0] ST_PUBLISH = 3'd4;
    localparam logic [2:0] ST_ABORT   = 3'd5;

    localparam logic [7:0] MPU_REG_ACCEL_XOUT_H = 8'h3B;
    localparam logic [6:0] MPU_DEV_ADDR         = 7'h68;
    localparam int         MPU_FRAME_BYTES      = 14;
    localparam int         WD_BITS              = 20;

    // The sensor registers are laid out high byte first.
    function automatic logic [15:0] be_word(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/mpu_frame_unpack.sv
// Combinational mapping from the 14-byte sensor shadow (byte 0 in the low
// bits) to the seven signed 16-bit sample words.
module mpu_frame_unpack
    import mpu_pkg::*;
(
    input  logic [MPU_FRAME_BYTES*8-1:0] frame_bytes,
    output logic signed [15:0]           accel_x,
    output logic signed [15:0]           accel_y,
    output logic signed [15:0]           accel_z,
    output logic signed [15:0]           temp,
    output logic signed [15:0]           gyro_x,
    output logic signed [15:0]           gyro_y,
    output logic signed [15:0]           gyro_z
);

    assign accel_x = be_word(frame_bytes[0*8  +: 8], frame_bytes[1*8  +: 8]);
    assign accel_y = be_word(frame_bytes[2*8  +: 8], frame_bytes[3*8  +: 8]);
    assign accel_z = be_word(frame_bytes[4*8  +: 8], frame_bytes[5*8  +: 8]);
    assign temp    = be_word(frame_bytes[6*8  +: 8], frame_bytes[7*8  +: 8]);
    assign gyro_x  = be_word(frame_bytes[8*8  +: 8], frame_bytes[9*8  +: 8]);
    assign gyro_y  = be_word(frame_bytes[10*8 +: 8], frame_bytes[11*8 +: 8]);
    assign gyro_z  = be_word(frame_bytes[12*8 +: 8], frame_bytes[13*8 +: 8]);

endmodule

// File: rtl/mpu_burst_reader.sv
// Reads the 14 MPU6050 sample bytes one register at a time on each timer tick
// and publishes the seven assembled words atomically with a valid strobe.
module mpu_burst_reader
    import mpu_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = MPU_DEV_ADDR,
    parameter logic [7:0] START_ADDR  = MPU_REG_ACCEL_XOUT_H,
    parameter int         NUM_BYTES   = MPU_FRAME_BYTES,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        tick_in,
    input  logic        enable_in,
    output logic        i2c_req_out,
    output logic [6:0]  i2c_dev_out,
    output logic [7:0]  i2c_reg_out,
    input  logic        i2c_busy_in,
    input  logic        i2c_done_in,
    input  logic        i2c_err_in,
    input  logic [7:0]  i2c_rdata_in,
    output logic [15:0] accel_x_out,
    output logic [15:0] accel_y_out,
    output logic [15:0] accel_z_out,
    output logic [15:0] temp_out,
    output logic [15:0] gyro_x_out,
    output logic [15:0] gyro_y_out,
    output logic [15:0] gyro_z_out,
    output logic        data_valid_out,
    output logic        busy_out,
    output logic        overrun_out,
    output logic        err_out
);

    localparam logic [3:0]         LAST_IDX = 4'(NUM_BYTES - 1);
    localparam logic [WD_BITS-1:0] WD_LAST  = WD_BITS'(TIMEOUT_CYC - 1);

    logic [2:0]             state_q;
    logic [3:0]             idx_q;
    logic [WD_BITS-1:0]     wd_q;
    logic [NUM_BYTES*8-1:0] shadow_q;

    logic signed [15:0] ax_w, ay_w, az_w, temp_w, gx_w, gy_w, gz_w;

    mpu_frame_unpack u_unpack (
        .frame_bytes (shadow_q),
        .accel_x     (ax_w),
        .accel_y     (ay_w),
        .accel_z     (az_w),
        .temp        (temp_w),
        .gyro_x      (gx_w),
        .gyro_y      (gy_w),
        .gyro_z      (gz_w)
    );

    assign i2c_dev_out    = DEV_ADDR;
    assign busy_out       = (state_q != ST_IDLE);
    assign data_valid_out = (state_q == ST_PUBLISH);
    assign err_out        = (state_q == ST_ABORT);
    assign overrun_out    = tick_in & enable_in & (state_q != ST_IDLE);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            wd_q        <= '0;
            // NOTE: the shadow buffer is small and is cleared on reset so a
            // partially read frame can never leak out after a reset.
            shadow_q    <= '0;
            i2c_req_out <= 1'b0;
            i2c_reg_out <= '0;
            accel_x_out <= '0;
            accel_y_out <= '0;
            accel_z_out <= '0;
            temp_out    <= '0;
            gyro_x_out  <= '0;
            gyro_y_out  <= '0;
            gyro_z_out  <= '0;
        end else begin
            i2c_req_out <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tick_in && enable_in) begin
                        idx_q   <= '0;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!i2c_busy_in) begin
                        i2c_req_out <= 1'b1;
                        i2c_reg_out <= START_ADDR + {4'b0000, idx_q};
                        wd_q        <= '0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A completion wins over a watchdog expiry in the same cycle.
                    if (i2c_done_in) begin
                        if (i2c_err_in) begin
                            state_q <= ST_ABORT;
                        end else begin
                            shadow_q[{idx_q, 3'b000} +: 8] <= i2c_rdata_in;
                            state_q                        <= ST_NEXT;
                        end
                    end else if (wd_q == WD_LAST) begin
                        state_q <= ST_ABORT;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (idx_q == LAST_IDX) begin
                        accel_x_out <= ax_w;
                        accel_y_out <= ay_w;
                        accel_z_out <= az_w;
                        temp_out    <= temp_w;
                        gyro_x_out  <= gx_w;
                        gyro_y_out  <= gy_w;
                        gyro_z_out  <= gz_w;
                        state_q     <= ST_PUBLISH;
                    end else begin
                        idx_q   <= idx_q + 4'd1;
                        state_q <= ST_REQ;
                    end
                end
                ST_PUBLISH: state_q <= ST_IDLE;
                ST_ABORT:   state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_burst_reader.sv
// Bench for mpu_burst_reader: a scripted I2C slave, an event-level frame model
// checked every cycle, and directed scenarios with hand-computed expectations.
module tb_mpu_burst_reader;

    localparam int TO = 40;
    localparam int NB = 14;

    logic        clk_in = 1'b0;
    logic        rst_n, tick_in, enable_in, hold_busy, sl_busy;
    logic        i2c_busy_in, i2c_done_in, i2c_err_in;
    logic [7:0]  i2c_rdata_in;
    logic        i2c_req_out, data_valid_out, busy_out, overrun_out, err_out;
    logic [6:0]  i2c_dev_out;
    logic [7:0]  i2c_reg_out;
    logic [15:0] accel_x_out, accel_y_out, accel_z_out, temp_out;
    logic [15:0] gyro_x_out, gyro_y_out, gyro_z_out;

    assign i2c_busy_in = sl_busy | hold_busy;

    mpu_burst_reader #(.TIMEOUT_CYC(TO)) dut (
        .clk_in         (clk_in),
        .rst_n          (rst_n),
        .tick_in        (tick_in),
        .enable_in      (enable_in),
        .i2c_req_out    (i2c_req_out),
        .i2c_dev_out    (i2c_dev_out),
        .i2c_reg_out    (i2c_reg_out),
        .i2c_busy_in    (i2c_busy_in),
        .i2c_done_in    (i2c_done_in),
        .i2c_err_in     (i2c_err_in),
        .i2c_rdata_in   (i2c_rdata_in),
        .accel_x_out    (accel_x_out),
        .accel_y_out    (accel_y_out),
        .accel_z_out    (accel_z_out),
        .temp_out       (temp_out),
        .gyro_x_out     (gyro_x_out),
        .gyro_y_out     (gyro_y_out),
        .gyro_z_out     (gyro_z_out),
        .data_valid_out (data_valid_out),
        .busy_out       (busy_out),
        .overrun_out    (overrun_out),
        .err_out        (err_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Slave: answers each request after 3 cycles with byte mem_base + index.
    logic [7:0] mem_base = 8'h01;
    logic       sl_hang = 1'b0;
    logic       nack_on = 1'b0;
    int         nack_idx = 0;
    int         sl_cnt;
    logic [7:0] sl_reg;

    initial begin
        sl_busy = 1'b0; i2c_done_in = 1'b0; i2c_err_in = 1'b0; i2c_rdata_in = 8'h00;
        sl_cnt = 0; sl_reg = 8'h00;
        forever begin
            @(posedge clk_in); #1;
            i2c_done_in = 1'b0;
            i2c_err_in  = 1'b0;
            if (!rst_n) begin
                sl_busy = 1'b0;
                sl_cnt  = 0;
            end else if (sl_cnt > 0) begin
                sl_cnt--;
                if (sl_cnt == 0) begin
                    i2c_done_in  = 1'b1;
                    i2c_rdata_in = mem_base + (sl_reg - 8'h3B);
                    i2c_err_in   = nack_on && (int'(sl_reg - 8'h3B) == nack_idx);
                    sl_busy      = 1'b0;
                end
            end else if (i2c_req_out && !sl_hang) begin
                sl_reg  = i2c_reg_out;
                sl_cnt  = 3;
                sl_busy = 1'b1;
            end
        end
    end

    // Frame model: tracks requests, delivered bytes and the published words.
    logic        m_busy = 1'b0;
    logic        m_outstanding = 1'b0;
    logic        prev_req = 1'b0;
    int          frame_req_cnt = 0, valid_due = -1, err_due = -1, m_req_cyc = 0;
    logic [7:0]  m_bytes[$];
    logic [15:0] m_words[7];
    int          valid_cnt = 0, err_cnt = 0, overrun_cnt = 0, req_cnt = 0;
    int          first_req_cyc = 0, last_req_cyc = 0, last_done_cyc = 0;
    int          valid_cyc = 0, err_cyc = 0;
    logic [7:0]  first_reg = 8'h00;

    always @(negedge clk_in) begin : compare
        logic [15:0] act_w[7];
        logic        exp_valid, exp_err, was_busy, to_hit;
        act_w[0] = accel_x_out; act_w[1] = accel_y_out; act_w[2] = accel_z_out;
        act_w[3] = temp_out;    act_w[4] = gyro_x_out;  act_w[5] = gyro_y_out;
        act_w[6] = gyro_z_out;
        if (!rst_n) begin
            m_busy = 1'b0; m_outstanding = 1'b0; prev_req = 1'b0;
            frame_req_cnt = 0; valid_due = -1; err_due = -1;
            m_bytes.delete();
            for (int k = 0; k < 7; k++) m_words[k] = 16'h0000;
            for (int k = 0; k < 7; k++) check("rst_word", act_w[k], 0);
            check("rst_valid", data_valid_out, 0);
            check("rst_err", err_out, 0);
            check("rst_req", i2c_req_out, 0);
            check("rst_busy", busy_out, 0);
            check("rst_overrun", overrun_out, 0);
        end else begin
            to_hit    = m_outstanding && (cyc == m_req_cyc + TO);
            exp_err   = (cyc == err_due) || to_hit;
            exp_valid = (cyc == valid_due);
            if (to_hit) m_outstanding = 1'b0;
            if (exp_valid)
                for (int k = 0; k < 7; k++) m_words[k] = {m_bytes[2*k], m_bytes[2*k+1]};
            check("valid", data_valid_out, exp_valid);
            check("err", err_out, exp_err);
            check("busy", busy_out, m_busy);
            check("overrun", overrun_out, tick_in & enable_in & m_busy);
            check("dev_addr", i2c_dev_out, 7'h68);
            for (int k = 0; k < 7; k++) check("word", act_w[k], m_words[k]);
            if (data_valid_out) begin valid_cnt++; valid_cyc = cyc; end
            if (err_out) begin err_cnt++; err_cyc = cyc; end
            if (overrun_out) overrun_cnt++;
            if (i2c_req_out) begin
                check("req_reg", i2c_reg_out, 32'h3B + frame_req_cnt);
                check("req_single", prev_req, 0);
                check("req_in_frame", m_busy, 1);
                if (frame_req_cnt == 0) begin
                    first_req_cyc = cyc;
                    first_reg     = i2c_reg_out;
                end
                frame_req_cnt++; req_cnt++;
                m_outstanding = 1'b1; m_req_cyc = cyc; last_req_cyc = cyc;
            end
            prev_req = i2c_req_out;
            if (i2c_done_in && m_outstanding) begin
                m_outstanding = 1'b0;
                last_done_cyc = cyc;
                if (i2c_err_in) err_due = cyc + 1;
                else begin
                    m_bytes.push_back(i2c_rdata_in);
                    if (m_bytes.size() == NB) valid_due = cyc + 2;
                end
            end
            was_busy = m_busy;
            if (exp_valid || exp_err) m_busy = 1'b0;
            if (tick_in && enable_in && !was_busy) begin
                m_busy = 1'b1; frame_req_cnt = 0; valid_due = -1; err_due = -1;
                m_bytes.delete();
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk_in); #1; end
    endtask

    task automatic pulse_tick();
        tick_in = 1'b1;
        step(1);
        tick_in = 1'b0;
    endtask

    task automatic wait_valid(input int start, input int limit, input string name);
        int n = 0;
        while (valid_cnt == start && n < limit) begin step(1); n++; end
        check(name, 32'(valid_cnt != start), 1);
    endtask

    task automatic wait_err(input int start, input int limit, input string name);
        int n = 0;
        while (err_cnt == start && n < limit) begin step(1); n++; end
        check(name, 32'(err_cnt != start), 1);
    endtask

    task automatic wait_reqs(input int target, input int limit, input string name);
        int n = 0;
        while (frame_req_cnt < target && n < limit) begin step(1); n++; end
        check(name, 32'(frame_req_cnt >= target), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int v0, r0, o0, e0, t0;
        rst_n = 1'b0; tick_in = 1'b0; enable_in = 1'b0; hold_busy = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(2);
        check("reset_accel_x", accel_x_out, 16'h0000);
        check("reset_busy", busy_out, 0);

        // Clean frame, bytes 0x01..0x0E
        enable_in = 1'b1; mem_base = 8'h01;
        step(1);
        v0 = valid_cnt; r0 = req_cnt; t0 = cyc;
        pulse_tick();
        wait_valid(v0, 400, "clean_wait");
        step(2);
        check("clean_valid_pulses", valid_cnt - v0, 1);
        check("clean_reqs", req_cnt - r0, 14);
        check("clean_first_req_lat", first_req_cyc - t0, 2);
        check("clean_first_reg", first_reg, 8'h3B);
        check("clean_valid_lat", valid_cyc - last_done_cyc, 2);
        check("clean_accel_x", accel_x_out, 16'h0102);
        check("clean_temp", temp_out, 16'h0708);
        check("clean_gyro_z", gyro_z_out, 16'h0D0E);

        // Second tick arriving while byte 5 is in flight
        mem_base = 8'h11; v0 = valid_cnt; o0 = overrun_cnt;
        pulse_tick();
        wait_reqs(6, 200, "ovr_wait_byte5");
        pulse_tick();
        wait_valid(v0, 400, "ovr_wait");
        step(2);
        check("ovr_overrun_pulses", overrun_cnt - o0, 1);
        check("ovr_valid_pulses", valid_cnt - v0, 1);
        check("ovr_accel_x", accel_x_out, 16'h1112);
        check("ovr_gyro_z", gyro_z_out, 16'h1D1E);

        // NACK on byte 9: abort, previous frame stays visible
        mem_base = 8'h21; nack_on = 1'b1; nack_idx = 9;
        v0 = valid_cnt; e0 = err_cnt;
        pulse_tick();
        wait_err(e0, 300, "nack_wait");
        step(2);
        check("nack_err_pulses", err_cnt - e0, 1);
        check("nack_no_valid", valid_cnt - v0, 0);
        check("nack_reqs", frame_req_cnt, 10);
        check("nack_keep_accel_x", accel_x_out, 16'h1112);
        check("nack_idle", busy_out, 0);
        nack_on = 1'b0; v0 = valid_cnt;
        pulse_tick();
        wait_valid(v0, 400, "nack_retry_wait");
        step(2);
        check("nack_retry_first_reg", first_reg, 8'h3B);
        check("nack_retry_accel_x", accel_x_out, 16'h2122);
        check("nack_retry_gyro_z", gyro_z_out, 16'h2D2E);

        // Slave never answers: watchdog abort TO cycles after the request
        sl_hang = 1'b1; e0 = err_cnt;
        pulse_tick();
        wait_err(e0, TO + 50, "to_wait");
        check("to_latency", err_cyc - last_req_cyc, TO);
        step(1);
        check("to_idle", busy_out, 0);
        check("to_keep_accel_x", accel_x_out, 16'h2122);
        sl_hang = 1'b0;

        // Tick while disabled is ignored silently
        enable_in = 1'b0; r0 = req_cnt; o0 = overrun_cnt;
        pulse_tick();
        step(10);
        check("gate_no_req", req_cnt - r0, 0);
        check("gate_no_overrun", overrun_cnt - o0, 0);
        check("gate_idle", busy_out, 0);
        enable_in = 1'b1;

        // Master busy for 50 cycles holds off the first request
        mem_base = 8'h41; hold_busy = 1'b1; r0 = req_cnt; v0 = valid_cnt;
        pulse_tick();
        step(50);
        check("bp_no_req", req_cnt - r0, 0);
        check("bp_busy", busy_out, 1);
        hold_busy = 1'b0;
        step(5);
        check("bp_one_req", req_cnt - r0, 1);
        wait_valid(v0, 400, "bp_wait");
        step(2);
        check("bp_accel_x", accel_x_out, 16'h4142);

        // Reset while byte 7 is in flight
        mem_base = 8'h51;
        pulse_tick();
        wait_reqs(8, 200, "rst_wait_byte7");
        rst_n = 1'b0;
        #1;
        check("midrst_accel_x", accel_x_out, 16'h0000);
        check("midrst_gyro_z", gyro_z_out, 16'h0000);
        check("midrst_busy", busy_out, 0);
        step(3);
        rst_n = 1'b1;
        step(2);
        mem_base = 8'h61; r0 = req_cnt; v0 = valid_cnt;
        pulse_tick();
        wait_valid(v0, 400, "postrst_wait");
        step(2);
        check("postrst_first_reg", first_reg, 8'h3B);
        check("postrst_reqs", req_cnt - r0, 14);
        check("postrst_accel_x", accel_x_out, 16'h6162);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
